// File: rtl/xadac_arb_if.sv
// xadac_arb_if: bundle of the decode/execute request and response handshakes
// of an xadac port, replicated N times (N=NumMst on the core side, N=1 on the
// accelerator side).
//   dec_req/_valid/_ready   decode request channel
//   dec_rsp/_valid/_ready   decode response channel
//   exe_req/_valid/_ready   execute request channel
//   exe_rsp/_valid/_ready   execute response channel
// Modports:
//   master - the side that issues requests and consumes responses
//   slave  - the side that accepts requests and produces responses
interface xadac_arb_if #(
    parameter int N       = 1,
    parameter int DecReqW = 32,
    parameter int DecRspW = 32,
    parameter int ExeReqW = 32,
    parameter int ExeRspW = 32
);
    logic [N-1:0][DecReqW-1:0] dec_req;
    logic [N-1:0]              dec_req_valid;
    logic [N-1:0]              dec_req_ready;
    logic [N-1:0][DecRspW-1:0] dec_rsp;
    logic [N-1:0]              dec_rsp_valid;
    logic [N-1:0]              dec_rsp_ready;
    logic [N-1:0][ExeReqW-1:0] exe_req;
    logic [N-1:0]              exe_req_valid;
    logic [N-1:0]              exe_req_ready;
    logic [N-1:0][ExeRspW-1:0] exe_rsp;
    logic [N-1:0]              exe_rsp_valid;
    logic [N-1:0]              exe_rsp_ready;

    modport master (
        output dec_req, dec_req_valid, dec_rsp_ready,
        output exe_req, exe_req_valid, exe_rsp_ready,
        input  dec_req_ready, dec_rsp, dec_rsp_valid,
        input  exe_req_ready, exe_rsp, exe_rsp_valid
    );

    modport slave (
        input  dec_req, dec_req_valid, dec_rsp_ready,
        input  exe_req, exe_req_valid, exe_rsp_ready,
        output dec_req_ready, dec_rsp, dec_rsp_valid,
        output exe_req_ready, exe_rsp, exe_rsp_valid
    );
endinterface

// File: rtl/xadac_arb.sv
// xadac_arb: shares one xadac accelerator port between NumMst core-side
// masters. Decode and execute channels are arbitrated independently, each by
// a round-robin arbiter with grant lock; responses are steered back to the
// requesting master through an in-order ID FIFO per channel.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   mst                  core-side port bundle (NumMst lanes, slave modport)
//   slv                  accelerator-side port bundle (1 lane, master modport)
//   perf_grant_cnt       per-master decode grant counters (XADAC_ARB_PERF_EN)
//   perf_full_stall_cnt  cycles a decode request waited on a full FIFO
//                        (XADAC_ARB_PERF_EN)
// Build option: define XADAC_ARB_PERF_EN to add the performance counters.

// One channel: combinational round-robin grant mux plus ID FIFO.
module xadac_arb_chan #(
    parameter int N     = 2,
    parameter int Depth = 4,
    parameter int ReqW  = 32,
    parameter int RspW  = 32,
    localparam int IdxW = (N > 1) ? $clog2(N) : 1,
    localparam int PtrW = $clog2(Depth),
    localparam int CntW = PtrW + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0][ReqW-1:0] mst_req,
    input  logic [N-1:0]           mst_req_valid,
    output logic [N-1:0]           mst_req_ready,
    output logic [N-1:0][RspW-1:0] mst_rsp,
    output logic [N-1:0]           mst_rsp_valid,
    input  logic [N-1:0]           mst_rsp_ready,
    output logic [ReqW-1:0]        slv_req,
    output logic                   slv_req_valid,
    input  logic                   slv_req_ready,
    input  logic [RspW-1:0]        slv_rsp,
    input  logic                   slv_rsp_valid,
    output logic                   slv_rsp_ready,
    output logic                   hs,
    output logic [IdxW-1:0]        gnt,
    output logic                   full
);
    logic [IdxW-1:0] rr_q, lock_idx_q, pick, head;
    logic            lock_q, found, empty, pop;
    logic [IdxW:0]   cand;
    logic [IdxW-1:0] id_mem [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q;

    // First valid master at or after rr_q, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, rr_q} + (IdxW+1)'(i);
            if (cand >= (IdxW+1)'(N)) cand = cand - (IdxW+1)'(N);
            if (!found && mst_req_valid[cand[IdxW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IdxW-1:0];
            end
        end
    end

    assign full  = (cnt_q == CntW'(Depth));
    assign empty = (cnt_q == '0);
    assign head  = id_mem[rd_ptr_q];

    // A stalled grant stays with its master until the slave takes it.
    assign gnt           = lock_q ? lock_idx_q : pick;
    assign slv_req       = mst_req[gnt];
    // When no master is valid, pick=0 and mst_req_valid[0]=0, so valid stays low.
    assign slv_req_valid = !full && mst_req_valid[gnt];
    assign hs            = slv_req_valid && slv_req_ready;

    always_comb begin
        mst_req_ready      = '0;
        mst_req_ready[gnt] = hs;
    end

    // Response steering by FIFO head; an empty FIFO holds off the slave.
    always_comb begin
        mst_rsp_valid = '0;
        if (!empty) mst_rsp_valid[head] = slv_rsp_valid;
        for (int i = 0; i < N; i++) mst_rsp[i] = slv_rsp;
    end

    assign slv_rsp_ready = !empty && mst_rsp_ready[head];
    assign pop           = slv_rsp_valid && slv_rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            if (slv_req_valid && !slv_req_ready) begin
                lock_q     <= 1'b1;
                lock_idx_q <= gnt;
            end else if (hs) begin
                lock_q <= 1'b0;
            end
            if (hs) begin
                rr_q     <= (gnt == IdxW'(N-1)) ? '0 : gnt + IdxW'(1);
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            cnt_q <= cnt_q + CntW'(hs) - CntW'(pop);
        end
    end

    // ID storage carries no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (hs) id_mem[wr_ptr_q] <= gnt;
    end
endmodule

module xadac_arb #(
    parameter int NumMst    = 2,
    parameter int FifoDepth = 4,
    parameter int DecReqW   = 32,
    parameter int DecRspW   = 32,
    parameter int ExeReqW   = 32,
    parameter int ExeRspW   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    xadac_arb_if.slave               mst,
    xadac_arb_if.master              slv
`ifdef XADAC_ARB_PERF_EN
    ,
    output logic [NumMst-1:0][31:0]  perf_grant_cnt,
    output logic [31:0]              perf_full_stall_cnt
`endif
);
    localparam int IdxW = (NumMst > 1) ? $clog2(NumMst) : 1;

    logic            dec_hs, dec_full, exe_hs, exe_full;
    logic [IdxW-1:0] dec_gnt, exe_gnt;

    xadac_arb_chan #(
        .N(NumMst), .Depth(FifoDepth), .ReqW(DecReqW), .RspW(DecRspW)
    ) u_dec (
        .clk           (clk),
        .rst           (rst),
        .mst_req       (mst.dec_req),
        .mst_req_valid (mst.dec_req_valid),
        .mst_req_ready (mst.dec_req_ready),
        .mst_rsp       (mst.dec_rsp),
        .mst_rsp_valid (mst.dec_rsp_valid),
        .mst_rsp_ready (mst.dec_rsp_ready),
        .slv_req       (slv.dec_req[0]),
        .slv_req_valid (slv.dec_req_valid[0]),
        .slv_req_ready (slv.dec_req_ready[0]),
        .slv_rsp       (slv.dec_rsp[0]),
        .slv_rsp_valid (slv.dec_rsp_valid[0]),
        .slv_rsp_ready (slv.dec_rsp_ready[0]),
        .hs            (dec_hs),
        .gnt           (dec_gnt),
        .full          (dec_full)
    );

    xadac_arb_chan #(
        .N(NumMst), .Depth(FifoDepth), .ReqW(ExeReqW), .RspW(ExeRspW)
    ) u_exe (
        .clk           (clk),
        .rst           (rst),
        .mst_req       (mst.exe_req),
        .mst_req_valid (mst.exe_req_valid),
        .mst_req_ready (mst.exe_req_ready),
        .mst_rsp       (mst.exe_rsp),
        .mst_rsp_valid (mst.exe_rsp_valid),
        .mst_rsp_ready (mst.exe_rsp_ready),
        .slv_req       (slv.exe_req[0]),
        .slv_req_valid (slv.exe_req_valid[0]),
        .slv_req_ready (slv.exe_req_ready[0]),
        .slv_rsp       (slv.exe_rsp[0]),
        .slv_rsp_valid (slv.exe_rsp_valid[0]),
        .slv_rsp_ready (slv.exe_rsp_ready[0]),
        .hs            (exe_hs),
        .gnt           (exe_gnt),
        .full          (exe_full)
    );

`ifdef XADAC_ARB_PERF_EN
    logic perf_unused;
    assign perf_unused = ^{exe_hs, exe_gnt, exe_full};

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant_cnt      <= '0;
            perf_full_stall_cnt <= '0;
        end else begin
            if (dec_hs) perf_grant_cnt[dec_gnt] <= perf_grant_cnt[dec_gnt] + 32'd1;
            if (dec_full && |mst.dec_req_valid)
                perf_full_stall_cnt <= perf_full_stall_cnt + 32'd1;
        end
    end
`else
    logic perf_unused;
    assign perf_unused = ^{dec_hs, dec_gnt, dec_full, exe_hs, exe_gnt, exe_full};
`endif
endmodule

// File: tb/tb_xadac_arb.sv
module tb_xadac_arb;
    localparam int NM  = 2;
    localparam int FD  = 4;
    localparam int DRQ = 32;
    localparam int DRS = 32;
    localparam int ERQ = 48;
    localparam int ERS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xadac_arb_if #(.N(NM), .DecReqW(DRQ), .DecRspW(DRS), .ExeReqW(ERQ), .ExeRspW(ERS)) mi();
    xadac_arb_if #(.N(1),  .DecReqW(DRQ), .DecRspW(DRS), .ExeReqW(ERQ), .ExeRspW(ERS)) si();

`ifdef XADAC_ARB_PERF_EN
    logic [NM-1:0][31:0] pgc;
    logic [31:0]         pfs;
`endif

    xadac_arb #(
        .NumMst(NM), .FifoDepth(FD), .DecReqW(DRQ), .DecRspW(DRS),
        .ExeReqW(ERQ), .ExeRspW(ERS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mst (mi),
        .slv (si)
`ifdef XADAC_ARB_PERF_EN
        ,
        .perf_grant_cnt      (pgc),
        .perf_full_stall_cnt (pfs)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per channel a round-robin pointer, an optional held
    // grant, and the list of outstanding master IDs in request order.
    int  rr  [2];
    bit  lk  [2];
    int  lki [2];
    int  qm  [2][16];
    int  qh  [2];
    int  qn  [2];
    bit [31:0] pm_gnt [NM];
    bit [31:0] pm_stall;

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            rr[c] = 0; lk[c] = 0; lki[c] = 0; qh[c] = 0; qn[c] = 0;
        end
        for (int k = 0; k < NM; k++) pm_gnt[k] = 0;
        pm_stall = 0;
    endtask

    task automatic model_chan(
        input int ch, input string nm,
        input logic [NM-1:0] vld, input logic [63:0] mreq [NM],
        input logic s_rdy, input logic rsp_v, input logic [NM-1:0] mrsp_rdy,
        input logic [NM-1:0] a_mrdy, input logic a_sv, input logic [63:0] a_sreq,
        input logic [NM-1:0] a_rspv, input logic a_srsp_rdy,
        input logic [63:0] srsp, input logic [63:0] a_mrsp [NM],
        output bit hs_o, output int g_o, output bit full_o);
        int g, h;
        bit found, full, ev, hs, pop;
        logic [NM-1:0] er, erv;
        full = (qn[ch] == FD);
        g = 0; found = 0;
        if (lk[ch]) begin
            g = lki[ch]; found = 1;
        end else begin
            for (int k = 0; k < NM; k++)
                if (!found && vld[(rr[ch] + k) % NM]) begin
                    g = (rr[ch] + k) % NM; found = 1;
                end
        end
        ev = found && !full && vld[g];
        hs = ev && s_rdy;
        er = '0;
        if (hs) er[g] = 1'b1;
        chk({nm, "_req_ready"}, 64'(a_mrdy), 64'(er));
        chk({nm, "_slv_req_valid"}, 64'(a_sv), 64'(ev));
        if (ev) chk({nm, "_slv_req"}, a_sreq, mreq[g]);
        erv = '0; pop = 0;
        if (qn[ch] > 0) begin
            h = qm[ch][qh[ch]];
            erv[h] = rsp_v;
            pop = rsp_v && mrsp_rdy[h];
            chk({nm, "_slv_rsp_ready"}, 64'(a_srsp_rdy), 64'(mrsp_rdy[h]));
        end else begin
            chk({nm, "_slv_rsp_ready_empty"}, 64'(a_srsp_rdy), 64'(0));
        end
        chk({nm, "_rsp_valid"}, 64'(a_rspv), 64'(erv));
        for (int k = 0; k < NM; k++)
            if (erv[k]) chk({nm, "_rsp_data"}, a_mrsp[k], srsp);
        if (pop) begin qh[ch] = (qh[ch] + 1) % 16; qn[ch]--; end
        if (hs) begin qm[ch][(qh[ch] + qn[ch]) % 16] = g; qn[ch]++; end
        if (ev && !s_rdy) begin lk[ch] = 1; lki[ch] = g; end
        else if (hs) lk[ch] = 0;
        if (hs) rr[ch] = (g + 1) % NM;
        hs_o = hs; g_o = g; full_o = full;
    endtask

    // Compare process: every cycle out of reset, check outputs against the model.
    always @(negedge clk) begin
        logic [63:0] mq [NM];
        logic [63:0] mr [NM];
        bit dhs, ehs, dfull, efull;
        int dg, eg;
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < NM; k++) begin
                mq[k] = 64'(mi.dec_req[k]);
                mr[k] = 64'(mi.dec_rsp[k]);
            end
            model_chan(0, "dec", mi.dec_req_valid, mq, si.dec_req_ready[0],
                       si.dec_rsp_valid[0], mi.dec_rsp_ready, mi.dec_req_ready,
                       si.dec_req_valid[0], 64'(si.dec_req[0]), mi.dec_rsp_valid,
                       si.dec_rsp_ready[0], 64'(si.dec_rsp[0]), mr, dhs, dg, dfull);
            for (int k = 0; k < NM; k++) begin
                mq[k] = 64'(mi.exe_req[k]);
                mr[k] = 64'(mi.exe_rsp[k]);
            end
            model_chan(1, "exe", mi.exe_req_valid, mq, si.exe_req_ready[0],
                       si.exe_rsp_valid[0], mi.exe_rsp_ready, mi.exe_req_ready,
                       si.exe_req_valid[0], 64'(si.exe_req[0]), mi.exe_rsp_valid,
                       si.exe_rsp_ready[0], 64'(si.exe_rsp[0]), mr, ehs, eg, efull);
`ifdef XADAC_ARB_PERF_EN
            for (int k = 0; k < NM; k++) chk("perf_grant_cnt", 64'(pgc[k]), 64'(pm_gnt[k]));
            chk("perf_full_stall_cnt", 64'(pfs), 64'(pm_stall));
            if (dhs) pm_gnt[dg] = pm_gnt[dg] + 1;
            if (dfull && |mi.dec_req_valid) pm_stall = pm_stall + 1;
`endif
        end
    end

    task automatic idle();
        mi.dec_req_valid = '0; mi.exe_req_valid = '0;
        mi.dec_rsp_ready = '0; mi.exe_rsp_ready = '0;
        si.dec_req_ready = '0; si.exe_req_ready = '0;
        si.dec_rsp_valid = '0; si.exe_rsp_valid = '0;
        for (int k = 0; k < NM; k++) begin
            mi.dec_req[k] = $urandom;
            mi.exe_req[k] = ERQ'({$urandom, $urandom});
        end
        si.dec_rsp[0] = $urandom;
        si.exe_rsp[0] = $urandom;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Reset for one cycle, then check the quiescent post-reset outputs.
    task automatic do_reset();
        step(); rst = 1'b1; idle();
        step(); rst = 1'b0;
        @(negedge clk);
        chk("rst_dec_req_ready", 64'(mi.dec_req_ready), 64'(0));
        chk("rst_exe_req_ready", 64'(mi.exe_req_ready), 64'(0));
        chk("rst_dec_slv_valid", 64'(si.dec_req_valid), 64'(0));
        chk("rst_exe_slv_valid", 64'(si.exe_req_valid), 64'(0));
        chk("rst_dec_rsp_valid", 64'(mi.dec_rsp_valid), 64'(0));
        chk("rst_exe_rsp_valid", 64'(mi.exe_rsp_valid), 64'(0));
        chk("rst_dec_slv_rsp_ready", 64'(si.dec_rsp_ready), 64'(0));
        chk("rst_exe_slv_rsp_ready", 64'(si.exe_rsp_ready), 64'(0));
    endtask

    logic [1:0] t1_gnt [4];
    logic [1:0] t1_rsp [4];

    initial begin
        idle();
        t1_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        t1_rsp = '{2'b00, 2'b01, 2'b10, 2'b01};
        repeat (2) step();

        // Both masters valid, slave always ready: grants and responses alternate.
        do_reset();
        step();
        mi.dec_req_valid = 2'b11; si.dec_req_ready = 1'b1;
        si.dec_rsp_valid = 1'b1;  mi.dec_rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("alt_grant", 64'(mi.dec_req_ready), 64'(t1_gnt[k]));
            chk("alt_rsp_route", 64'(mi.dec_rsp_valid), 64'(t1_rsp[k]));
            step();
        end

        // Grant lock: master1 waits on a stalled slave while master0 joins.
        do_reset();
        step();
        mi.dec_req[0] = 32'h0A0A_0A0A; mi.dec_req[1] = 32'h0B0B_0B0B;
        mi.dec_req_valid = 2'b10; si.dec_req_ready = 1'b0;
        @(negedge clk);
        chk("lock_c0_valid", 64'(si.dec_req_valid[0]), 64'(1));
        chk("lock_c0_req", 64'(si.dec_req[0]), 64'h0B0B_0B0B);
        step(); mi.dec_req_valid = 2'b11;
        @(negedge clk);
        chk("lock_c1_req", 64'(si.dec_req[0]), 64'h0B0B_0B0B);
        chk("lock_c1_ready", 64'(mi.dec_req_ready), 64'(0));
        step();
        @(negedge clk);
        chk("lock_c2_req", 64'(si.dec_req[0]), 64'h0B0B_0B0B);
        step(); si.dec_req_ready = 1'b1;
        @(negedge clk);
        chk("lock_hs_m1", 64'(mi.dec_req_ready), 64'(2'b10));
        step();
        @(negedge clk);
        chk("lock_next_m0", 64'(mi.dec_req_ready), 64'(2'b01));

        // FIFO full: four accepted, then stalled; a pop frees a slot a cycle later.
        do_reset();
        step();
        mi.dec_req_valid = 2'b01; si.dec_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("full_accept", 64'(mi.dec_req_ready), 64'(2'b01));
            step();
        end
        @(negedge clk);
        chk("full_stall", 64'(mi.dec_req_ready), 64'(0));
        step(); si.dec_rsp_valid = 1'b1; mi.dec_rsp_ready = 2'b01;
        @(negedge clk);
        chk("full_pop_no_ready", 64'(mi.dec_req_ready), 64'(0));
        chk("full_pop_rsp", 64'(mi.dec_rsp_valid), 64'(2'b01));
        step(); si.dec_rsp_valid = 1'b0;
        @(negedge clk);
        chk("full_fifth_accept", 64'(mi.dec_req_ready), 64'(2'b01));

        // Response with nothing outstanding is held until its request exists.
        do_reset();
        step(); si.exe_rsp_valid = 1'b1; mi.exe_rsp_ready = 2'b11;
        @(negedge clk);
        chk("early_rsp_ready", 64'(si.exe_rsp_ready[0]), 64'(0));
        chk("early_rsp_valid", 64'(mi.exe_rsp_valid), 64'(0));
        step(); mi.exe_req_valid = 2'b10; si.exe_req_ready = 1'b1;
        @(negedge clk);
        chk("early_req_hs", 64'(mi.exe_req_ready), 64'(2'b10));
        step(); mi.exe_req_valid = 2'b00;
        @(negedge clk);
        chk("early_rsp_to_m1", 64'(mi.exe_rsp_valid), 64'(2'b10));
        chk("early_rsp_ready_m1", 64'(si.exe_rsp_ready[0]), 64'(1));

        // Concurrent channels, then reset mid-stream.
        do_reset();
        step();
        mi.dec_req_valid = 2'b01; mi.exe_req_valid = 2'b10;
        si.dec_req_ready = 1'b1;  si.exe_req_ready = 1'b1;
        si.dec_rsp_valid = 1'b1;  si.exe_rsp_valid = 1'b1;
        mi.dec_rsp_ready = 2'b11; mi.exe_rsp_ready = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("conc_dec", 64'(mi.dec_req_ready), 64'(2'b01));
            chk("conc_exe", 64'(mi.exe_req_ready), 64'(2'b10));
            step();
        end
        do_reset();
        step(); mi.dec_req_valid = 2'b11; si.dec_req_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_rr0", 64'(mi.dec_req_ready), 64'(2'b01));

`ifdef XADAC_ARB_PERF_EN
        do_reset();
        chk("perf_rst0", 64'(pgc[0]), 64'(0));
        step();
        si.dec_req_ready = 1'b1; si.dec_rsp_valid = 1'b1; mi.dec_rsp_ready = 2'b11;
        mi.dec_req_valid = 2'b01;
        repeat (5) step();
        mi.dec_req_valid = 2'b10;
        repeat (3) step();
        idle();
        @(negedge clk);
        chk("perf_m0_5", 64'(pgc[0]), 64'd5);
        chk("perf_m1_3", 64'(pgc[1]), 64'd3);
        do_reset();
        chk("perf_clr0", 64'(pgc[0]), 64'(0));
        chk("perf_clr1", 64'(pgc[1]), 64'(0));
`endif

        // Randomized traffic against the model, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            mi.dec_req_valid = NM'($urandom); mi.exe_req_valid = NM'($urandom);
            mi.dec_rsp_ready = NM'($urandom); mi.exe_rsp_ready = NM'($urandom);
            si.dec_req_ready = ($urandom_range(0, 3) != 0);
            si.exe_req_ready = ($urandom_range(0, 3) != 0);
            si.dec_rsp_valid = ($urandom_range(0, 9) < 3);
            si.exe_rsp_valid = ($urandom_range(0, 9) < 3);
            for (int k = 0; k < NM; k++) begin
                mi.dec_req[k] = $urandom;
                mi.exe_req[k] = ERQ'({$urandom, $urandom});
            end
            si.dec_rsp[0] = $urandom;
            si.exe_rsp[0] = $urandom;
        end
        step(); rst = 1'b0; idle();
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xadac_arb.md
Name: xadac_arb

Overview:
- Shares one xadac accelerator slave port between NumMst core-side master ports.
- Decode and execute channels are arbitrated independently; both use round-robin with grant lock.
- Responses return to their originating master through per-channel in-order ID FIFOs. The slave responds in request order on each channel.
- Sits between the issue-side xadac masters and a single accelerator instance.

Parameters:
- NumMst, 2, number of master ports (2..8).
- FifoDepth, 4, outstanding requests tracked per channel (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- mst_dec_req  in  NumMst x DecReqT  master decode requests.
- mst_dec_req_valid  in  NumMst  per-master valid.
- mst_dec_req_ready  out  NumMst  per-master ready.
- mst_dec_rsp  out  NumMst x DecRspT  decode responses, broadcast copy of slv_dec_rsp.
- mst_dec_rsp_valid  out  NumMst  per-master response valid.
- mst_dec_rsp_ready  in  NumMst  per-master response ready.
- mst_exe_req / _valid / _ready  in/in/out  NumMst x ExeReqT / NumMst / NumMst  same rules as the decode request ports.
- mst_exe_rsp / _valid / _ready  out/out/in  NumMst x ExeRspT / NumMst / NumMst  same rules as the decode response ports.
- slv_dec_req  out  DecReqT  to accelerator; slv_dec_req_valid out 1; slv_dec_req_ready in 1.
- slv_dec_rsp  in  DecRspT  from accelerator; slv_dec_rsp_valid in 1; slv_dec_rsp_ready out 1.
- slv_exe_req  out  ExeReqT; slv_exe_req_valid out 1; slv_exe_req_ready in 1.
- slv_exe_rsp  in  ExeRspT; slv_exe_rsp_valid in 1; slv_exe_rsp_ready out 1.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and rst.
- Both channels (dec, exe) use identical logic; each is described once below.
- Request path is combinational, 0-cycle latency: the slave request, its valid, and the ready of the granted master come from the grant mux.
- Grant selection:
  - Lowest index at or after rr_q (wrapping) with valid=1 wins.
  - Grant is allowed only when the ID FIFO is not full.
  - When the FIFO is full: slv_*_req_valid=0 and all mst_*_req_ready=0, even if a pop occurs the same cycle.
- Grant lock:
  - If slv_*_req_valid=1 and slv_*_req_ready=0, lock_q=1 and the granted index is held in lock_idx_q.
  - The next cycle uses that index regardless of rr_q or other valids.
  - Lock clears on the handshake.
- Only the granted master sees ready; all others see 0.
- On request handshake: push the granted index into the ID FIFO; rr_q <= (granted+1) mod NumMst.
- Response path, combinational:
  - The FIFO head selects the target master: mst_*_rsp_valid[head]=slv_*_rsp_valid, all other masters 0.
  - slv_*_rsp_ready = mst_*_rsp_ready[head].
  - On response handshake, pop the head.
- FIFO empty: slv_*_rsp_ready=0 and all mst_*_rsp_valid=0. Any slave response in this state is held off, not dropped.
- Push and pop in the same cycle when the FIFO is neither full nor empty: occupancy is unchanged.
- Pointers wrap modulo FifoDepth. Count width is clog2(FifoDepth)+1.
- Dec and exe channels never interact: simultaneous grants on both channels to different masters are legal.
- Reset state:
  - rr_q=0, lock_q=0, lock_idx_q=0, FIFOs empty.
  - Hence all slv_*_req_valid=0, mst_*_req_ready=0, mst_*_rsp_valid=0, slv_*_rsp_ready=0 during and right after reset.
- Reset mid-operation: all outstanding IDs and locks are discarded. The accelerator is reset by the same rst.

Optional Feature:
- Macro: XADAC_ARB_PERF_EN.
- When defined:
  - Extra output perf_grant_cnt, NumMst x 32, one counter per master. Increments on each dec request handshake to that master; wraps at 2^32-1 to 0; cleared by rst.
  - Extra output perf_full_stall_cnt, 32, increments every cycle any master has dec_req_valid=1 while the dec FIFO is full.
- When undefined: neither port nor the counters exist. Functional behaviour is otherwise identical.

Test Plan:
- NumMst=2, both masters hold dec_req_valid=1, slave ready=1 always -> grants alternate 0,1,0,1 over 4 cycles; responses routed to 0,1,0,1.
- Master1 valid, slave ready=0 for 3 cycles, master0 asserts valid in cycle 2 -> grant stays 1 until handshake in cycle 4, then master0 is granted in cycle 5.
- FifoDepth=4, slave never responds, master0 streams requests -> exactly 4 handshakes, then mst_dec_req_ready[0]=0. One response pops an entry -> the 5th request is accepted the next cycle.
- slv_exe_rsp_valid=1 with empty exe FIFO -> slv_exe_rsp_ready=0 and no mst_exe_rsp_valid. A later request from master1 -> the pending response is delivered to master1 only.
- Master0 dec stream and master1 exe stream concurrently -> both channels accept every cycle with no cross-blocking. Assert rst mid-stream -> next cycle all valids/readies are 0 and rr_q=0.
- XADAC_ARB_PERF_EN defined, 5 handshakes to master0 and 3 to master1 -> perf_grant_cnt = {3,5} (index 1, index 0); counters read 0 after rst.
